csr_unit: RTL

- Execute-stage functional unit for Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms).
- Accepts one issued CSR op and reads the CSR file. Checks read and write permission through two internal csr_access_check instances: WRITE_PREMISSION=0 for read, WRITE_PREMISSION=1 for write.
- Computes the new CSR value and hands the result to writeback/ROB. Writeback carries the rd value, a deferred CSR write (applied at commit) or an illegal-instruction flag.

---
 rtl/csr_unit_if.sv | 44 ++++
 rtl/csr_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/csr_unit_if.sv
// csr_unit_if: issue and writeback handshake bundle for the Zicsr execute unit.
//   master: issue side driver / writeback consumer (pipeline, ROB)
//   slave : the csr_unit itself
// Signals: issue_valid/ready + issue_* fields; wb_valid/ready + wb_* result fields.
interface csr_unit_if #(
  parameter int XLEN           = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int ROB_ID_WIDTH   = 5
);
  logic                      issue_valid;
  logic                      issue_ready;
  logic [1:0]                issue_op;
  logic                      issue_imm;
  logic [4:0]                issue_rs1_id;
  logic [XLEN-1:0]           issue_src1_value;
  logic [CSR_ADDR_WIDTH-1:0] issue_csr_addr;
  logic [4:0]                issue_rd_id;
  logic [ROB_ID_WIDTH-1:0]   issue_rob_id;

  logic                      wb_valid;
  logic                      wb_ready;
  logic [ROB_ID_WIDTH-1:0]   wb_rob_id;
  logic [4:0]                wb_rd_id;
  logic                      wb_rd_enable;
  logic [XLEN-1:0]           wb_rd_value;
  logic                      wb_csr_we;
  logic [CSR_ADDR_WIDTH-1:0] wb_csr_waddr;
  logic [XLEN-1:0]           wb_csr_wdata;
  logic                      wb_illegal;

  modport master (
    output issue_valid, issue_op, issue_imm, issue_rs1_id, issue_src1_value,
           issue_csr_addr, issue_rd_id, issue_rob_id, wb_ready,
    input  issue_ready, wb_valid, wb_rob_id, wb_rd_id, wb_rd_enable, wb_rd_value,
           wb_csr_we, wb_csr_waddr, wb_csr_wdata, wb_illegal
  );

  modport slave (
    input  issue_valid, issue_op, issue_imm, issue_rs1_id, issue_src1_value,
           issue_csr_addr, issue_rd_id, issue_rob_id, wb_ready,
    output issue_ready, wb_valid, wb_rob_id, wb_rd_id, wb_rd_enable, wb_rd_value,
           wb_csr_we, wb_csr_waddr, wb_csr_wdata, wb_illegal
  );
endinterface

// File: rtl/csr_unit.sv
// csr_access_check: combinational permission check for one CSR address.
//   csr_addr_i : CSR address
//   valid_o    : address is implemented and (for write checks) writable
// The core runs these CSRs in machine mode, so only existence and the
// read-only address region (addr[11:10]==2'b11) are checked.
module csr_access_check #(
  parameter bit WRITE_PREMISSION = 1'b0,
  parameter int CSR_ADDR_WIDTH   = 12
) (
  input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i,
  output logic                      valid_o
);
  logic known;

  always_comb begin
    known = 1'b0;
    case (csr_addr_i)
      12'h300, 12'h301, 12'h304, 12'h305,
      12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB02, 12'hC00, 12'hC02,
      12'hF11, 12'hF12, 12'hF13, 12'hF14: known = 1'b1;
      default:                            known = 1'b0;
    endcase
    valid_o = known &&
              (!WRITE_PREMISSION || (csr_addr_i[CSR_ADDR_WIDTH-1 -: 2] != 2'b11));
  end
endmodule

// csr_unit: execute-stage unit for CSRRW/CSRRS/CSRRC (+ immediate forms).
//   clk, rst   : clock, synchronous active-high reset
//   flush      : pipeline flush, drops any op in flight
//   bus        : issue handshake in, writeback handshake out (csr_unit_if.slave)
//   csr_raddr  : CSR file read address (registered, holds after an op)
//   csr_rdata  : CSR file read data, combinational from csr_raddr
// The CSR write is deferred: it is reported on wb_csr_* for the ROB to
// apply at commit, never performed here.
module csr_unit #(
  parameter int XLEN           = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int ROB_ID_WIDTH   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  csr_unit_if.slave                 bus,
  output logic [CSR_ADDR_WIDTH-1:0] csr_raddr,
  input  logic [XLEN-1:0]           csr_rdata
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [1:0] {OP_RSV = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} op_e;

  state_e state_q, state_d;
  logic   issue_ready_q, issue_ready_d;
  logic   wb_valid_q, wb_valid_d;
  logic   accept, load_wb;

  // latched issue fields; addr_q doubles as the CSR read address
  op_e                       op_q;
  logic                      imm_q;
  logic [4:0]                rs1_q;
  logic [XLEN-1:0]           src1_q;
  logic [CSR_ADDR_WIDTH-1:0] addr_q;
  logic [4:0]                rd_q;
  logic [ROB_ID_WIDTH-1:0]   rob_q;

  logic [ROB_ID_WIDTH-1:0]   wb_rob_q;
  logic [4:0]                wb_rd_id_q;
  logic                      wb_rd_en_q, wb_we_q, wb_ill_q;
  logic [XLEN-1:0]           wb_rd_val_q, wb_wdata_q;
  logic [CSR_ADDR_WIDTH-1:0] wb_waddr_q;

  logic            rd_ok, wr_ok, write_intent, illegal;
  logic [XLEN-1:0] operand, new_val;

  csr_access_check #(.WRITE_PREMISSION(1'b0), .CSR_ADDR_WIDTH(CSR_ADDR_WIDTH)) u_rd_check (
    .csr_addr_i(addr_q), .valid_o(rd_ok)
  );
  csr_access_check #(.WRITE_PREMISSION(1'b1), .CSR_ADDR_WIDTH(CSR_ADDR_WIDTH)) u_wr_check (
    .csr_addr_i(addr_q), .valid_o(wr_ok)
  );

  // Datapath: rs1_id is both the register index and the uimm, so the
  // write-intent test on it is the same for both forms.
  always_comb begin
    operand      = imm_q ? {{(XLEN-5){1'b0}}, rs1_q} : src1_q;
    write_intent = (op_q == OP_RW) || (op_q[1] && (rs1_q != '0));
    case (op_q)
      OP_RW:   new_val = operand;
      OP_RS:   new_val = csr_rdata | operand;
      OP_RC:   new_val = csr_rdata & ~operand;
      default: new_val = '0;
    endcase
    illegal = (op_q == OP_RSV) || !rd_ok || (write_intent && !wr_ok);
  end

  always_comb begin
    state_d       = state_q;
    issue_ready_d = issue_ready_q;
    wb_valid_d    = wb_valid_q;
    accept        = 1'b0;
    load_wb       = 1'b0;
    case (state_q)
      IDLE: if (bus.issue_valid) begin
        accept        = 1'b1;
        issue_ready_d = 1'b0;
        state_d       = EXEC;
      end
      EXEC: begin
        load_wb    = 1'b1;
        wb_valid_d = 1'b1;
        state_d    = DONE;
      end
      DONE: if (bus.wb_ready) begin
        wb_valid_d    = 1'b0;
        issue_ready_d = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        wb_valid_d    = 1'b0;
        issue_ready_d = 1'b1;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      issue_ready_q <= 1'b1;
      wb_valid_q    <= 1'b0;
      op_q          <= OP_RSV;
      imm_q         <= 1'b0;
      rs1_q         <= '0;
      src1_q        <= '0;
      addr_q        <= '0;
      rd_q          <= '0;
      rob_q         <= '0;
      wb_rob_q      <= '0;
      wb_rd_id_q    <= '0;
      wb_rd_en_q    <= 1'b0;
      wb_rd_val_q   <= '0;
      wb_we_q       <= 1'b0;
      wb_waddr_q    <= '0;
      wb_wdata_q    <= '0;
      wb_ill_q      <= 1'b0;
    end else if (flush) begin
      // flush aborts the op but keeps the last read address on csr_raddr
      state_q       <= IDLE;
      issue_ready_q <= 1'b1;
      wb_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_ready_q <= issue_ready_d;
      wb_valid_q    <= wb_valid_d;
      if (accept) begin
        op_q   <= op_e'(bus.issue_op);
        imm_q  <= bus.issue_imm;
        rs1_q  <= bus.issue_rs1_id;
        src1_q <= bus.issue_src1_value;
        addr_q <= bus.issue_csr_addr;
        rd_q   <= bus.issue_rd_id;
        rob_q  <= bus.issue_rob_id;
      end
      if (load_wb) begin
        wb_rob_q    <= rob_q;
        wb_rd_id_q  <= rd_q;
        wb_ill_q    <= illegal;
        wb_rd_en_q  <= !illegal && (rd_q != '0);
        wb_rd_val_q <= illegal ? '0 : csr_rdata;
        wb_we_q     <= !illegal && write_intent;
        wb_waddr_q  <= illegal ? '0 : addr_q;
        wb_wdata_q  <= illegal ? '0 : new_val;
      end
    end
  end

  assign csr_raddr        = addr_q;
  assign bus.issue_ready  = issue_ready_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rob_id    = wb_rob_q;
  assign bus.wb_rd_id     = wb_rd_id_q;
  assign bus.wb_rd_enable = wb_rd_en_q;
  assign bus.wb_rd_value  = wb_rd_val_q;
  assign bus.wb_csr_we    = wb_we_q;
  assign bus.wb_csr_waddr = wb_waddr_q;
  assign bus.wb_csr_wdata = wb_wdata_q;
  assign bus.wb_illegal   = wb_ill_q;
endmodule
